// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART constants and types. The divide constants are used by the baud
// generator; the receiver uses the oversample ratio and the rx state type.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int CLK_FREQ   = 50_000_000;
    localparam int BAUD       = 115200;
    localparam int OVERSAMPLE = 16;

    // 50 MHz / (115200 * 16) = 27.13, rounded up to one rxclk_en every 28 clocks
    localparam int RX_DIV = (CLK_FREQ + BAUD * OVERSAMPLE - 1) / (BAUD * OVERSAMPLE);
    localparam int TX_DIV = CLK_FREQ / BAUD;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Bundles the receiver's line, strobe and host-side signals.
//   clken     : 16x oversample strobe from the baud generator
//   rx        : asynchronous serial line, idle high
//   rdy_clr   : host acknowledge, clears rdy and overrun
//   data      : last correctly framed byte
//   rdy       : sticky byte-available flag
//   frame_err : last frame had a low stop bit
//   overrun   : sticky, byte completed while rdy was still set
// slave  = receiver side, master = host/driver side.
// -----------------------------------------------------------------------------
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 clken;
    logic                 rx;
    logic                 rdy_clr;
    logic [DATA_BITS-1:0] data;
    logic                 rdy;
    logic                 frame_err;
    logic                 overrun;

    modport slave (
        input  clken,
        input  rx,
        input  rdy_clr,
        output data,
        output rdy,
        output frame_err,
        output overrun
    );

    modport master (
        output clken,
        output rx,
        output rdy_clr,
        input  data,
        input  rdy,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for an asynchronous input that idles high. Both flops
// reset to 1 so a reset never looks like a falling edge downstream.
//   clk_50m : system clock
//   reset   : asynchronous active-high reset
//   d       : asynchronous input
//   q       : synchronised output, two clocks of latency
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk_50m,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver driven by the 16x oversample strobe. Qualifies the start
// bit at its midpoint, samples every data bit and the stop bit at mid-bit and
// presents the byte with a sticky ready flag plus framing/overrun status.
//   clk_50m : system clock
//   reset   : asynchronous active-high reset
//   bus     : uart_rx_if.slave (clken, rx, rdy_clr in; data, rdy,
//             frame_err, overrun out)
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk_50m,
    input  logic      reset,
    uart_rx_if.slave  bus
);
    import uart_pkg::*;

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [SW-1:0] MID_START = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] LAST_TICK = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    rx_state_t            state;
    logic [SW-1:0]        sample;
    logic [BW-1:0]        bitidx;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] data_r;
    logic                 rdy_r;
    logic                 frame_err_r;
    logic                 overrun_r;
    logic                 rx_s;

    uart_rx_sync u_sync (
        .clk_50m (clk_50m),
        .reset   (reset),
        .d       (bus.rx),
        .q       (rx_s)
    );

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sample      <= '0;
            bitidx      <= '0;
            shift       <= '0;
            data_r      <= '0;
            rdy_r       <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            // Host acknowledge works on any cycle; a completion below overrides it.
            if (bus.rdy_clr) begin
                rdy_r     <= 1'b0;
                overrun_r <= 1'b0;
            end

            if (bus.clken) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state  <= START;
                            sample <= '0;
                        end
                    end

                    START: begin
                        sample <= sample + SW'(1);
                        if (sample == MID_START) begin
                            // Line back high at mid start bit: treat as a glitch.
                            if (!rx_s) begin
                                state  <= DATA;
                                sample <= '0;
                                bitidx <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end

                    DATA: begin
                        // Counter restarted at mid start bit, so a full wrap lands mid-bit.
                        sample <= sample + SW'(1);
                        if (sample == LAST_TICK) begin
                            shift[bitidx] <= rx_s;
                            if (bitidx == LAST_BIT) begin
                                state  <= STOP;
                                sample <= '0;
                            end else begin
                                bitidx <= bitidx + BW'(1);
                            end
                        end
                    end

                    STOP: begin
                        sample <= sample + SW'(1);
                        if (sample == LAST_TICK) begin
                            state <= IDLE;
                            if (rx_s) begin
                                data_r      <= shift;
                                frame_err_r <= 1'b0;
                                rdy_r       <= 1'b1;
                                overrun_r   <= rdy_r && !bus.rdy_clr;
                            end else begin
                                frame_err_r <= 1'b1;
                            end
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.data      = data_r;
    assign bus.rdy       = rdy_r;
    assign bus.frame_err = frame_err_r;
    assign bus.overrun   = overrun_r;
endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx: free-running 1-in-28 clken, frames driven
// at 16 ticks per bit, good frames pushed to a scoreboard and popped when the
// receiver reports completion.
// -----------------------------------------------------------------------------
module tb_uart_rx;
    import uart_pkg::*;

    logic clk_50m = 1'b0;
    logic reset   = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;

    uart_rx_if bus ();

    uart_rx dut (
        .clk_50m (clk_50m),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #10 clk_50m = ~clk_50m;

    // Oversample strobe: one clock high every RX_DIV clocks
    initial begin
        bus.clken = 1'b0;
        forever begin
            repeat (RX_DIV - 1) @(negedge clk_50m);
            bus.clken = 1'b1;
            @(negedge clk_50m);
            bus.clken = 1'b0;
        end
    end

    initial begin
        #(20 * 95000);
        $display("FAIL watchdog: simulation did not finish within 95000 cycles");
        $fatal(1, "watchdog");
    end

    // Wait for n clken ticks; returns 1 ns after the last active edge.
    task automatic tick(input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            @(posedge clk_50m);
            while (bus.clken !== 1'b1 && guard < 64) begin
                @(posedge clk_50m);
                guard++;
            end
            if (guard >= 64) begin
                checks++;
                failures++;
                $display("FAIL tick_timeout: clken not seen within 64 cycles");
            end
        end
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        bus.rx = 1'b0;
        tick(16);
        for (int i = 0; i < nbits; i++) begin
            bus.rx = b[i];
            tick(16);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bits(b, 8);
        if (stop) exp_q.push_back(b);
        bus.rx = stop;
        tick(16);
        bus.rx = 1'b1;
    endtask

    task automatic pulse_rdy_clr();
        @(negedge clk_50m);
        bus.rdy_clr = 1'b1;
        @(posedge clk_50m);
        #1;
        bus.rdy_clr = 1'b0;
    endtask

    task automatic check_good(input string name);
        logic [7:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_sb: completion with empty scoreboard, data=%02h", name, bus.data);
        end else begin
            exp = exp_q.pop_front();
            last_good = exp;
            if (bus.data !== exp) begin
                failures++;
                $display("FAIL %s_data: got %02h expected %02h", name, bus.data, exp);
            end
        end
        checks++;
        if (bus.rdy !== 1'b1) begin
            failures++;
            $display("FAIL %s_rdy: got %b expected 1", name, bus.rdy);
        end
        checks++;
        if (bus.frame_err !== 1'b0) begin
            failures++;
            $display("FAIL %s_frame_err: got %b expected 0", name, bus.frame_err);
        end
    endtask

    task automatic test_reset();
        bus.rx      = 1'b1;
        bus.rdy_clr = 1'b0;
        #2 reset = 1'b1;
        repeat (5) @(posedge clk_50m);
        #1 reset = 1'b0;
        repeat (1000) @(posedge clk_50m);
        #1;
        checks++;
        if (bus.rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy: got %b expected 0", bus.rdy); end
        checks++;
        if (bus.data !== 8'h00) begin failures++; $display("FAIL reset_data: got %02h expected 00", bus.data); end
        checks++;
        if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
        checks++;
        if (bus.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
        checks++;
        if (dut.state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected IDLE", dut.state); end
    endtask

    task automatic test_basic();
        send_bits(8'hA5, 8);
        exp_q.push_back(8'hA5);
        bus.rx = 1'b1;
        tick(8);
        checks++;
        if (bus.rdy !== 1'b0) begin failures++; $display("FAIL basic_rdy_early: got %b expected 0", bus.rdy); end
        tick(1);
        check_good("basic");
        tick(7);
        pulse_rdy_clr();
        checks++;
        if (bus.rdy !== 1'b0) begin failures++; $display("FAIL basic_rdy_clr: got %b expected 0", bus.rdy); end
        tick(8);
    endtask

    task automatic test_glitch();
        bus.rx = 1'b0;
        tick(4);
        bus.rx = 1'b1;
        tick(12);
        checks++;
        if (dut.state !== IDLE) begin failures++; $display("FAIL glitch_state: got %0d expected IDLE", dut.state); end
        checks++;
        if (bus.rdy !== 1'b0) begin failures++; $display("FAIL glitch_rdy: got %b expected 0", bus.rdy); end
        checks++;
        if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL glitch_frame_err: got %b expected 0", bus.frame_err); end
        send_frame(8'h3C, 1'b1);
        check_good("after_glitch");
        pulse_rdy_clr();
        tick(8);
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0);
        tick(32);
        checks++;
        if (bus.frame_err !== 1'b1) begin failures++; $display("FAIL ferr_flag: got %b expected 1", bus.frame_err); end
        checks++;
        if (bus.rdy !== 1'b0) begin failures++; $display("FAIL ferr_rdy: got %b expected 0", bus.rdy); end
        checks++;
        if (bus.data !== last_good) begin failures++; $display("FAIL ferr_data: got %02h expected %02h", bus.data, last_good); end
        send_frame(8'h5A, 1'b1);
        check_good("after_ferr");
        pulse_rdy_clr();
        tick(8);
    endtask

    task automatic test_back_to_back();
        int guard;
        send_frame(8'h11, 1'b1);
        check_good("b2b_first");
        checks++;
        if (bus.overrun !== 1'b0) begin failures++; $display("FAIL b2b_first_overrun: got %b expected 0", bus.overrun); end
        send_frame(8'h22, 1'b1);
        check_good("b2b_second");
        checks++;
        if (bus.overrun !== 1'b1) begin failures++; $display("FAIL b2b_overrun: got %b expected 1", bus.overrun); end

        // Third byte: rdy_clr lands on the stop-sample clken edge
        send_bits(8'h33, 8);
        exp_q.push_back(8'h33);
        bus.rx = 1'b1;
        tick(8);
        guard = 0;
        do begin
            @(negedge clk_50m);
            #1;
            guard++;
        end while (bus.clken !== 1'b1 && guard < 64);
        bus.rdy_clr = 1'b1;
        @(posedge clk_50m);
        #1;
        bus.rdy_clr = 1'b0;
        check_good("b2b_clr_collide");
        checks++;
        if (bus.overrun !== 1'b0) begin failures++; $display("FAIL b2b_clr_overrun: got %b expected 0", bus.overrun); end
        tick(7);
        tick(8);
    endtask

    task automatic test_reset_midframe();
        send_bits(8'hF0, 3);
        bus.rx = 1'b0;   // bit 3 of 0xF0
        tick(8);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.data !== 8'h00) begin failures++; $display("FAIL midrst_data: got %02h expected 00", bus.data); end
        checks++;
        if (bus.rdy !== 1'b0) begin failures++; $display("FAIL midrst_rdy: got %b expected 0", bus.rdy); end
        checks++;
        if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL midrst_frame_err: got %b expected 0", bus.frame_err); end
        checks++;
        if (bus.overrun !== 1'b0) begin failures++; $display("FAIL midrst_overrun: got %b expected 0", bus.overrun); end
        checks++;
        if (dut.state !== IDLE) begin failures++; $display("FAIL midrst_state: got %0d expected IDLE", dut.state); end
        bus.rx = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(4);
        send_frame(8'h96, 1'b1);
        check_good("after_midrst");
        checks++;
        if (bus.overrun !== 1'b0) begin failures++; $display("FAIL after_midrst_overrun: got %b expected 0", bus.overrun); end
    endtask

    initial begin
        bus.rx      = 1'b1;
        bus.rdy_clr = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. Sits directly downstream of the baud-rate generator and consumes its 16x-oversample strobe `rxclk_en`.
- Synchronises the asynchronous `rx` line, qualifies the start bit and samples each bit at mid-bit.
- Presents the byte with a sticky ready flag that the host clears.
- Reports framing and overrun errors.

Parameters:
- DATA_BITS, 8, number of data bits per frame, LSB first.
- OVERSAMPLE, 16, clken ticks per bit period; must match the baud generator's rx ratio.

Ports:
- clk_50m  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- clken  in  1  single-cycle oversample strobe (`rxclk_en`, one pulse every 28 clk_50m cycles).
- rx  in  1  serial line, idle high, asynchronous to clk_50m.
- rdy_clr  in  1  host acknowledge; clears rdy and overrun.
- data  out  DATA_BITS  last correctly framed byte.
- rdy  out  1  sticky byte-available flag.
- frame_err  out  1  last frame had stop bit = 0.
- overrun  out  1  sticky; byte completed while rdy was already 1.

Behaviour:
- Reset (async, active-high):
  - State IDLE; sample counter and bit index 0; shift register 0.
  - Synchroniser flops reset to 1 (idle line).
  - data = 0, rdy = 0, frame_err = 0, overrun = 0.
- rx passes through a 2-flop synchroniser to give rx_s; 2 clk_50m cycles of latency.
- State machine: IDLE, START, DATA, STOP. All state, counter and shift updates occur only on cycles with clken = 1. rdy_clr acts on any cycle.
- IDLE: on clken with rx_s = 0, go to START with sample = 0.
- START:
  - Each clken increments sample.
  - When sample = OVERSAMPLE/2-1 (7), i.e. mid start bit:
    - rx_s = 0: go to DATA, sample = 0, bitidx = 0.
    - rx_s = 1: glitch; go back to IDLE. No flags change.
- DATA:
  - Each clken increments sample, 4-bit, wrapping.
  - At sample = OVERSAMPLE-1: shift[bitidx] = rx_s.
  - If bitidx = DATA_BITS-1, go to STOP with sample = 0; otherwise bitidx++.
  - Sampling therefore lands at mid-bit.
- STOP: at sample = OVERSAMPLE-1, go to IDLE and evaluate rx_s:
  - rx_s = 1: data = shift; frame_err = 0; rdy = 1; if rdy was already 1, overrun = 1.
  - rx_s = 0: frame_err = 1; data and rdy unchanged.
- Latency: data, rdy and frame_err update one clk_50m cycle after the clken on which the stop bit is sampled.
- rdy_clr:
  - Clears rdy and overrun on the next edge.
  - If rdy_clr coincides with a completion cycle, the completion wins: rdy = 1, data updated, overrun = 0.
- frame_err holds until the next completed frame; rdy_clr does not affect it.
- Back-to-back frames: a start bit detected immediately after the mid-stop sample is accepted. No idle gap is required.
- Reset mid-frame: immediate return to IDLE, all outputs 0, partial byte discarded.
- clken stuck low: FSM freezes; no timeout.
- Line held low (break): once the break runs past the first byte it produces repeated frame_err frames.

Decomposition:
- Package uart_pkg holds:
  - CLK_FREQ = 50_000_000, BAUD = 115200, OVERSAMPLE = 16.
  - RX_DIV / TX_DIV divide constants, shared with the baud generator.
  - The enumerated rx state type (IDLE, START, DATA, STOP).
- One natural sub-module: uart_rx_sync, a 2-flop synchroniser with async reset to 1. Reused later for cts and other async inputs.

Test Plan:
- Reset, then hold rx = 1 for 1000 cycles -> rdy = 0, data = 0x00, frame_err = 0, overrun = 0, FSM in IDLE.
- Free-running clken (1 per 28 clocks). Send 0xA5 at 16 clken per bit, stop = 1 -> rdy rises about 9.5 bit times after the start edge; data = 0xA5, frame_err = 0. Pulse rdy_clr -> rdy = 0 next cycle.
- Drive rx low for 4 clken ticks, then high -> no rdy, no frame_err, FSM back in IDLE. Then send 0x3C -> data = 0x3C.
- Send 0x3C with stop bit = 0 -> frame_err = 1, rdy = 0, data unchanged. Then send 0x5A -> data = 0x5A, frame_err = 0.
- Send 0x11, then 0x22 back-to-back with no rdy_clr -> data = 0x22, rdy = 1, overrun = 1. Next, assert rdy_clr on the exact completion cycle of a third byte 0x33 -> rdy = 1, data = 0x33, overrun = 0.
- Assert reset during data bit 3 of 0xF0 -> all outputs 0 immediately. Release reset, send 0x96 -> data = 0x96, rdy = 1.
